// File: rtl/truth_table_scanner_if.sv
// Bus between the truth-table scanner, its control source and the gate under test.
// The master side drives the sweep request, the expected table and the gate output.
// The slave side is the scanner, which drives the test vector and reports results.
interface truth_table_scanner_if #(
  parameter int N_IN = 5
);
  localparam int NV = 1 << N_IN;

  logic              start;
  logic              abort;
  logic [NV-1:0]     expected_tt;
  logic              dut_y;
  logic [N_IN-1:0]   dut_in;
  logic              busy;
  logic              done;
  logic              result_valid;
  logic [NV-1:0]     truth_table;
  logic [N_IN:0]     mismatch_cnt;
  logic [N_IN-1:0]   first_fail_idx;
  logic              pass;

  modport master (
    output start, abort, expected_tt, dut_y,
    input  dut_in, busy, done, result_valid, truth_table,
           mismatch_cnt, first_fail_idx, pass
  );

  modport slave (
    input  start, abort, expected_tt, dut_y,
    output dut_in, busy, done, result_valid, truth_table,
           mismatch_cnt, first_fail_idx, pass
  );
endinterface

// File: rtl/truth_table_scanner.sv
// Exhaustive truth-table scanner: walks every input vector of an N_IN-input
// combinational gate, holds each vector SETTLE cycles, samples the gate output
// on the last cycle of the hold, and compares the captured table against a
// table latched at sweep start. SETTLE must lie in 1..15.
module truth_table_scanner #(
  parameter int N_IN   = 5,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_scanner_if.slave  bus
);
  localparam int NV = 1 << N_IN;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST    = '1;

  logic [1:0]      state_q,     state_d;
  logic [N_IN-1:0] idx_q,       idx_d;
  logic [3:0]      settle_q,    settle_d;
  logic [N_IN-1:0] dut_in_q,    dut_in_d;
  logic [NV-1:0]   exp_q,       exp_d;
  logic [NV-1:0]   tt_q,        tt_d;
  logic [N_IN:0]   mcnt_q,      mcnt_d;
  logic [N_IN-1:0] ffi_q,       ffi_d;
  logic            fail_seen_q, fail_seen_d;
  logic            busy_q,      busy_d;
  logic            rv_q,        rv_d;

  // Next-state logic: sweep sequencing, sampling and mismatch accounting
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    settle_d    = settle_q;
    dut_in_d    = dut_in_q;
    exp_d       = exp_q;
    tt_d        = tt_q;
    mcnt_d      = mcnt_q;
    ffi_d       = ffi_q;
    fail_seen_d = fail_seen_q;
    busy_d      = busy_q;
    rv_d        = rv_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          exp_d       = bus.expected_tt;
          idx_d       = '0;
          dut_in_d    = '0;
          settle_d    = '0;
          tt_d        = '0;
          mcnt_d      = '0;
          ffi_d       = '0;
          fail_seen_d = 1'b0;
          rv_d        = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_HOLD;
        end
      end

      S_HOLD: begin
        // An abort takes priority over a sample falling in the same cycle,
        // so a sweep aborted on its final vector never reports completion.
        if (bus.abort) begin
          busy_d  = 1'b0;
          rv_d    = 1'b0;
          state_d = S_IDLE;
        end else if (settle_q == SETTLE_LAST) begin
          tt_d[idx_q] = bus.dut_y;
          if (bus.dut_y != exp_q[idx_q]) begin
            mcnt_d = mcnt_q + 1'b1;
            if (!fail_seen_q) begin
              ffi_d       = idx_q;
              fail_seen_d = 1'b1;
            end
          end
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d    = idx_q + 1'b1;
            dut_in_d = idx_q + 1'b1;
            settle_d = '0;
          end
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        rv_d    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      settle_q    <= '0;
      dut_in_q    <= '0;
      exp_q       <= '0;
      tt_q        <= '0;
      mcnt_q      <= '0;
      ffi_q       <= '0;
      fail_seen_q <= 1'b0;
      busy_q      <= 1'b0;
      rv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      settle_q    <= settle_d;
      dut_in_q    <= dut_in_d;
      exp_q       <= exp_d;
      tt_q        <= tt_d;
      mcnt_q      <= mcnt_d;
      ffi_q       <= ffi_d;
      fail_seen_q <= fail_seen_d;
      busy_q      <= busy_d;
      rv_q        <= rv_d;
    end
  end

  assign bus.dut_in         = dut_in_q;
  assign bus.busy           = busy_q;
  assign bus.done           = (state_q == S_DONE);
  assign bus.result_valid   = rv_q;
  assign bus.truth_table    = tt_q;
  assign bus.mismatch_cnt   = mcnt_q;
  assign bus.first_fail_idx = ffi_q;
  assign bus.pass           = rv_q && (mcnt_q == '0);
endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: a behavioural gate model (parity, tied-high or
// random lookup) feeds dut_y, and results are predicted from the gate's
// function over all 32 vectors.
module tb_truth_table_scanner;
  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [1:0]  gmode;
  logic [31:0] gtab;
  logic [4:0]  trace  [0:255];
  logic        btrace [0:255];

  truth_table_scanner_if #(.N_IN(5)) bus  ();
  truth_table_scanner_if #(.N_IN(5)) bus1 ();

  assign bus.dut_y  = (gmode == 2'd0) ? ^bus.dut_in  : (gmode == 2'd1) ? 1'b1 : gtab[bus.dut_in];
  assign bus1.dut_y = (gmode == 2'd0) ? ^bus1.dut_in : (gmode == 2'd1) ? 1'b1 : gtab[bus1.dut_in];

  truth_table_scanner #(.N_IN(5), .SETTLE(2)) u_dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  truth_table_scanner #(.N_IN(5), .SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: truth table of the modelled gate, computed per vector
  function automatic logic [31:0] model_tt(input logic [1:0] m, input logic [31:0] g);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) begin
      case (m)
        2'd0:    r[k] = ($countones(k) % 2) == 1;
        2'd1:    r[k] = 1'b1;
        default: r[k] = g[k];
      endcase
    end
    return r;
  endfunction

  function automatic int model_cnt(input logic [31:0] tt, input logic [31:0] e);
    return $countones(tt ^ e);
  endfunction

  function automatic int model_ffi(input logic [31:0] tt, input logic [31:0] e);
    for (int k = 0; k < 32; k++) if (tt[k] != e[k]) return k;
    return 0;
  endfunction

  // Drive one start pulse and follow the sweep until done; cyc=0 on timeout
  task automatic run_sweep(input logic [31:0] e, output int cyc);
    @(negedge clk);
    bus.expected_tt = e;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.expected_tt = ~e;
    cyc = 1;
    trace[1] = bus.dut_in;
    btrace[1] = bus.busy;
    while (!bus.done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      trace[cyc] = bus.dut_in;
      btrace[cyc] = bus.busy;
    end
    if (!bus.done) cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 0; bus.abort = 0; bus.expected_tt = '0;
    bus1.start = 0; bus1.abort = 0; bus1.expected_tt = '0;
    gmode = 2'd0; gtab = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.result_valid, bus.pass, bus.dut_in, bus.truth_table,
         bus.mismatch_cnt, bus.first_fail_idx} !== 52'd0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b rv=%b pass=%b dut_in=%0d tt=%h cnt=%0d ffi=%0d required all 0",
               bus.busy, bus.done, bus.result_valid, bus.pass, bus.dut_in, bus.truth_table,
               bus.mismatch_cnt, bus.first_fail_idx);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dut_in !== 5'd0) begin
      failures++;
      $display("FAIL post_reset_idle: busy=%b done=%b dut_in=%0d required 0 0 0", bus.busy, bus.done, bus.dut_in);
    end
  endtask

  task automatic test_parity();
    int cyc;
    logic [31:0] tt;
    gmode = 2'd0;
    tt = model_tt(2'd0, '0);
    checks++;
    if (tt !== 32'h96696996) begin
      failures++;
      $display("FAIL parity_model: got %h required 96696996", tt);
    end
    run_sweep(32'h96696996, cyc);
    checks++;
    if (cyc !== 65) begin
      failures++;
      $display("FAIL parity_latency: done in cycle %0d required 65", cyc);
    end
    @(negedge clk);
    checks++;
    if (bus.truth_table !== tt || bus.mismatch_cnt !== 6'd0 || bus.pass !== 1'b1 ||
        bus.first_fail_idx !== 5'd0 || bus.result_valid !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL parity_result: tt=%h cnt=%0d ffi=%0d pass=%b rv=%b busy=%b done=%b required %h 0 0 1 1 0 0",
               bus.truth_table, bus.mismatch_cnt, bus.first_fail_idx, bus.pass, bus.result_valid,
               bus.busy, bus.done, tt);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.result_valid !== 1'b1 || bus.pass !== 1'b1) begin
      failures++;
      $display("FAIL idle_abort_ignored: rv=%b pass=%b required 1 1", bus.result_valid, bus.pass);
    end
  endtask

  task automatic test_mismatch();
    logic [31:0] exps [0:1];
    int cyc;
    logic [31:0] tt;
    exps[0] = 32'h96796997;
    exps[1] = 32'h96796996;
    gmode = 2'd0;
    tt = model_tt(2'd0, '0);
    for (int i = 0; i < 2; i++) begin
      run_sweep(exps[i], cyc);
      @(negedge clk);
      checks++;
      if (cyc !== 65 || bus.mismatch_cnt !== 6'(model_cnt(tt, exps[i])) ||
          bus.first_fail_idx !== 5'(model_ffi(tt, exps[i])) || bus.pass !== 1'b0) begin
        failures++;
        $display("FAIL mismatch_%0d: cyc=%0d cnt=%0d ffi=%0d pass=%b required 65 %0d %0d 0",
                 i, cyc, bus.mismatch_cnt, bus.first_fail_idx, bus.pass,
                 model_cnt(tt, exps[i]), model_ffi(tt, exps[i]));
      end
    end
  endtask

  task automatic test_tied_one();
    int cyc;
    int bad;
    gmode = 2'd1;
    run_sweep(32'h0, cyc);
    bad = 0;
    for (int c = 1; c <= 64; c++) if (trace[c] !== 5'((c - 1) / 2)) bad++;
    if (trace[65] !== 5'd31) bad++;
    checks++;
    if (bad != 0 || cyc !== 65) begin
      failures++;
      $display("FAIL vector_dwell: %0d cycles with wrong dut_in, cyc=%0d, required 0 and 65", bad, cyc);
    end
    bad = 0;
    for (int c = 1; c <= 65; c++) if (btrace[c] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL busy_during_sweep: %0d cycles with busy low, required 0", bad);
    end
    @(negedge clk);
    checks++;
    if (bus.truth_table !== 32'hFFFFFFFF || bus.mismatch_cnt !== 6'd32 ||
        bus.first_fail_idx !== 5'd0 || bus.pass !== 1'b0 || bus.dut_in !== 5'd31) begin
      failures++;
      $display("FAIL tied_one_result: tt=%h cnt=%0d ffi=%0d pass=%b dut_in=%0d required ffffffff 32 0 0 31",
               bus.truth_table, bus.mismatch_cnt, bus.first_fail_idx, bus.pass, bus.dut_in);
    end
  endtask

  task automatic test_random();
    int cyc;
    logic [31:0] e;
    logic [31:0] tt;
    int nflip;
    for (int r = 0; r < 6; r++) begin
      gmode = 2'd2;
      gtab = $urandom;
      tt = model_tt(2'd2, gtab);
      if (r == 5) e = $urandom;
      else begin
        e = tt;
        nflip = $urandom_range(3, 0);
        for (int j = 0; j < nflip; j++) e[$urandom_range(31, 0)] ^= 1'b1;
      end
      run_sweep(e, cyc);
      @(negedge clk);
      checks++;
      if (cyc !== 65 || bus.truth_table !== tt || bus.mismatch_cnt !== 6'(model_cnt(tt, e)) ||
          bus.first_fail_idx !== 5'(model_ffi(tt, e)) || bus.pass !== (model_cnt(tt, e) == 0)) begin
        failures++;
        $display("FAIL random_%0d: cyc=%0d tt=%h cnt=%0d ffi=%0d pass=%b required 65 %h %0d %0d %b",
                 r, cyc, bus.truth_table, bus.mismatch_cnt, bus.first_fail_idx, bus.pass,
                 tt, model_cnt(tt, e), model_ffi(tt, e), model_cnt(tt, e) == 0);
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] e;
    logic [31:0] part;
    int ndone;
    int cyc;
    gmode = 2'd2;
    gtab = $urandom;
    e = $urandom;
    @(negedge clk);
    bus.expected_tt = e;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 2; c <= 20; c++) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    part = gtab & 32'h000001FF;
    checks++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.done !== 1'b0 ||
        bus.truth_table !== part || bus.dut_in !== 5'd9 ||
        bus.mismatch_cnt !== 6'(model_cnt(part, e & 32'h000001FF))) begin
      failures++;
      $display("FAIL abort_state: busy=%b rv=%b done=%b tt=%h dut_in=%0d cnt=%0d required 0 0 0 %h 9 %0d",
               bus.busy, bus.result_valid, bus.done, bus.truth_table, bus.dut_in, bus.mismatch_cnt,
               part, model_cnt(part, e & 32'h000001FF));
    end
    ndone = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      failures++;
      $display("FAIL abort_no_done: %0d done pulses required 0", ndone);
    end
    gtab = $urandom;
    run_sweep(gtab, cyc);
    @(negedge clk);
    checks++;
    if (cyc !== 65 || bus.truth_table !== gtab || bus.pass !== 1'b1) begin
      failures++;
      $display("FAIL after_abort_sweep: cyc=%0d tt=%h pass=%b required 65 %h 1", cyc, bus.truth_table, bus.pass, gtab);
    end
  endtask

  task automatic test_async_reset();
    int ndone;
    logic was_busy;
    gmode = 2'd1;
    @(negedge clk);
    bus.expected_tt = '0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (30) @(negedge clk);
    was_busy = bus.busy;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (was_busy !== 1'b1 || {bus.busy, bus.done, bus.result_valid, bus.pass, bus.dut_in, bus.truth_table,
         bus.mismatch_cnt, bus.first_fail_idx} !== 52'd0) begin
      failures++;
      $display("FAIL async_reset: was_busy=%b busy=%b rv=%b dut_in=%0d tt=%h cnt=%0d required 1 then all 0",
               was_busy, bus.busy, bus.result_valid, bus.dut_in, bus.truth_table, bus.mismatch_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.done || bus.busy) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      failures++;
      $display("FAIL reset_no_resume: %0d cycles with done/busy required 0", ndone);
    end
  endtask

  task automatic test_back_to_back();
    int ndone;
    int adj;
    logic prev;
    int guard;
    gmode = 2'd0;
    @(negedge clk);
    bus.expected_tt = 32'h96696996;
    bus.start = 1'b1;
    ndone = 0; adj = 0; prev = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (bus.done) ndone++;
      if (bus.done && prev) adj++;
      prev = bus.done;
    end
    bus.start = 1'b0;
    checks++;
    if (ndone != 3 || adj != 0) begin
      failures++;
      $display("FAIL held_start: %0d done pulses, %0d wide pulses, required 3 and 0", ndone, adj);
    end
    guard = 0;
    while (!bus.done && guard < 150) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    checks++;
    if (guard >= 150 || bus.pass !== 1'b1 || bus.truth_table !== 32'h96696996) begin
      failures++;
      $display("FAIL held_start_final: guard=%0d pass=%b tt=%h required <150 1 96696996", guard, bus.pass, bus.truth_table);
    end
  endtask

  task automatic test_settle1();
    int cyc;
    logic [31:0] tt;
    gmode = 2'd0;
    tt = model_tt(2'd0, '0);
    @(negedge clk);
    bus1.expected_tt = 32'h96696996;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    cyc = 1;
    while (!bus1.done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus1.done) cyc = 0;
    @(negedge clk);
    checks++;
    if (cyc !== 33 || bus1.truth_table !== tt || bus1.pass !== 1'b1 || bus1.mismatch_cnt !== 6'd0) begin
      failures++;
      $display("FAIL settle1_sweep: done cycle %0d tt=%h pass=%b cnt=%0d required 33 %h 1 0",
               cyc, bus1.truth_table, bus1.pass, bus1.mismatch_cnt, tt);
    end
  endtask

  initial begin
    test_reset();
    test_parity();
    test_mismatch();
    test_tied_one();
    test_random();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_settle1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
